// File: rtl/rst_seq_pkg.sv
// rst_seq_pkg: shared types and constants for the reset sequencer.
//   state_t  - sequencer states (RESET, ASSERT, RELEASE, RUN)
//   cause_t  - last reset cause reported on cause_o (POR, SW, WDT)
//   CAUSE_W  - width of the cause field
//   max_int  - elaboration-time helper used to size the hold/gap counter
package rst_seq_pkg;

  localparam int CAUSE_W = 2;

  typedef enum logic [1:0] {
    ST_RESET,
    ST_ASSERT,
    ST_RELEASE,
    ST_RUN
  } state_t;

  typedef enum logic [CAUSE_W-1:0] {
    CAUSE_POR = 2'd0,
    CAUSE_SW  = 2'd1,
    CAUSE_WDT = 2'd2
  } cause_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rst_seq_if.sv
// rst_seq_if: request/status bundle between the reset sequencer and its clients.
//   sw_req_i  - software reset request (single-cycle pulse)
//   wdt_req_i - watchdog reset request (level or pulse)
//   rst_n_o   - active-low per-domain resets, bit k released k-th
//   busy_o    - high while the sequencer is not in RUN
//   cause_o   - last reset cause
// With RST_SEQ_ACK_EN defined it also carries:
//   rst_ack_i - per-domain "out of reset" acknowledge (already synchronized)
//   err_o     - sticky acknowledge-timeout flag
// Modports: master = the requesting/observing side, slave = rst_seq itself.
interface rst_seq_if #(
  parameter int DOMAINS = 3
);
  import rst_seq_pkg::*;

  logic               sw_req_i;
  logic               wdt_req_i;
  logic [DOMAINS-1:0] rst_n_o;
  logic               busy_o;
  cause_t             cause_o;
`ifdef RST_SEQ_ACK_EN
  logic [DOMAINS-1:0] rst_ack_i;
  logic               err_o;

  modport master (output sw_req_i, wdt_req_i, rst_ack_i,
                  input  rst_n_o, busy_o, cause_o, err_o);
  modport slave  (input  sw_req_i, wdt_req_i, rst_ack_i,
                  output rst_n_o, busy_o, cause_o, err_o);
`else
  modport master (output sw_req_i, wdt_req_i,
                  input  rst_n_o, busy_o, cause_o);
  modport slave  (input  sw_req_i, wdt_req_i,
                  output rst_n_o, busy_o, cause_o);
`endif

endinterface

// File: rtl/rst_seq_tmr.sv
// rst_seq_tmr: loadable down-counter with a zero flag.
//   clk_i, rst_i - clock and asynchronous active-high reset (count clears to 0)
//   load         - load 'value' into the counter (wins over en)
//   value        - load value
//   en           - decrement by one per edge; the count holds at zero
//   zero         - count is zero
module rst_seq_tmr #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load,
  input  logic [W-1:0] value,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] count;

  // NOTE: state registers use non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (en && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/rst_seq.sv
// rst_seq: ordered reset sequencer for DOMAINS downstream reset domains.
// All rst_n_o bits assert together on any reset cause (power-on rst_i, software
// request, watchdog request), stay asserted HOLD_CYC cycles, then release one
// domain per GAP_CYC cycles in index order; RUN follows GAP_CYC cycles after
// the last release. All outputs are registered.
//   clk_i  - free-running clock
//   rst_i  - asynchronous active-high power-on reset
//   bus    - rst_seq_if.slave (requests in; rst_n_o, busy_o, cause_o out)
// Optional feature macro RST_SEQ_ACK_EN: each release step additionally waits
// for rst_ack_i of the previously released domain, giving up after
// ACK_TIMEOUT extra cycles and raising the sticky err_o.
module rst_seq
  import rst_seq_pkg::*;
#(
  parameter int DOMAINS  = 3,
  parameter int HOLD_CYC = 16,
  parameter int GAP_CYC  = 4
`ifdef RST_SEQ_ACK_EN
  , parameter int ACK_TIMEOUT = 64
`endif
) (
  input logic     clk_i,
  input logic     rst_i,
  rst_seq_if.slave bus
);

  localparam int CNT_W = $clog2(max_int(HOLD_CYC, GAP_CYC) + 1);
  localparam int IDX_W = $clog2(DOMAINS + 1);
  localparam logic [CNT_W-1:0]   HOLD_LD  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0]   GAP_LD   = CNT_W'(GAP_CYC - 1);
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(DOMAINS);
  localparam logic [DOMAINS-1:0] BIT0     = DOMAINS'(1);

  state_t             state;
  cause_t             cause;
  logic [DOMAINS-1:0] rst_n;
  logic               busy;
  logic [IDX_W-1:0]   idx;   // number of domains already released

  logic               cnt_load;
  logic [CNT_W-1:0]   cnt_value;
  logic               cnt_zero;
  logic               wdt_hit;
  logic               sw_hit;
  logic               gap_done;
  logic               advance;

  // The watchdog is honoured everywhere except the one-cycle RESET state;
  // software requests only count in RUN and are otherwise dropped.
  assign wdt_hit  = bus.wdt_req_i && (state != ST_RESET);
  assign sw_hit   = bus.sw_req_i && (state == ST_RUN);
  assign gap_done = (state == ST_RELEASE) && cnt_zero;

`ifdef RST_SEQ_ACK_EN
  localparam int WAIT_W = $clog2(ACK_TIMEOUT + 1);

  logic ack_ok;
  logic waiting;
  logic wait_zero;
  logic timeout;
  logic err;

  // Acknowledge of the most recently released domain, bit idx-1.
  assign ack_ok  = |(bus.rst_ack_i & (BIT0 << (idx - IDX_W'(1))));
  assign waiting = gap_done && !ack_ok;
  assign timeout = waiting && wait_zero;
  assign advance = gap_done && (ack_ok || timeout);

  // Kept preloaded with ACK_TIMEOUT while not waiting, so it reaches zero
  // after exactly ACK_TIMEOUT waiting cycles.
  rst_seq_tmr #(.W(WAIT_W)) u_wait_tmr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .load  (!waiting),
    .value (WAIT_W'(ACK_TIMEOUT)),
    .en    (waiting),
    .zero  (wait_zero)
  );

  assign bus.err_o = err;
`else
  assign advance = gap_done;
`endif

  // NOTE: every signal written here gets a default first, so no path through
  // the block leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_load  = 1'b0;
    cnt_value = HOLD_LD;
    if ((state == ST_RESET) || wdt_hit || sw_hit) begin
      cnt_load = 1'b1;
    end else if (((state == ST_ASSERT) && cnt_zero) ||
                 (advance && (idx != LAST_IDX))) begin
      cnt_load  = 1'b1;
      cnt_value = GAP_LD;
    end
  end

  rst_seq_tmr #(.W(CNT_W)) u_cnt_tmr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .load  (cnt_load),
    .value (cnt_value),
    .en    ((state == ST_ASSERT) || (state == ST_RELEASE)),
    .zero  (cnt_zero)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= ST_RESET;
      rst_n <= '0;
      busy  <= 1'b1;
      cause <= CAUSE_POR;
      idx   <= '0;
`ifdef RST_SEQ_ACK_EN
      err   <= 1'b0;
`endif
    end else begin
`ifdef RST_SEQ_ACK_EN
      err <= err | timeout;
`endif
      if (wdt_hit || sw_hit) begin
        // Watchdog beats a simultaneous software request.
        state <= ST_ASSERT;
        rst_n <= '0;
        busy  <= 1'b1;
        cause <= wdt_hit ? CAUSE_WDT : CAUSE_SW;
        idx   <= '0;
      end else begin
        case (state)
          ST_RESET: state <= ST_ASSERT;
          ST_ASSERT: begin
            if (cnt_zero) begin
              state <= ST_RELEASE;
              rst_n <= BIT0;
              idx   <= IDX_W'(1);
            end
          end
          ST_RELEASE: begin
            if (advance) begin
              if (idx == LAST_IDX) begin
                state <= ST_RUN;
                busy  <= 1'b0;
              end else begin
                rst_n <= rst_n | (BIT0 << idx);
                idx   <= idx + IDX_W'(1);
              end
            end
          end
          default: ;  // ST_RUN: hold until a request arrives
        endcase
      end
    end
  end

  assign bus.rst_n_o = rst_n;
  assign bus.busy_o  = busy;
  assign bus.cause_o = cause;

endmodule

// File: tb/tb_rst_seq.sv
// tb_rst_seq: self-checking bench for rst_seq (DOMAINS=3, HOLD_CYC=16, GAP_CYC=4).
// Directed table of request/edge-count/expected-output records, hand-written
// async-reset and (with RST_SEQ_ACK_EN) acknowledge-timeout sequences, then a
// randomized run checked against an age-based reference model.
module tb_rst_seq;
  import rst_seq_pkg::*;

  localparam int DOMAINS = 3;
  localparam int HOLD    = 16;
  localparam int GAP     = 4;
  localparam int RUN_AGE = HOLD + DOMAINS * GAP;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  always #5 clk_i = ~clk_i;

  rst_seq_if #(.DOMAINS(DOMAINS)) bus ();

`ifdef RST_SEQ_ACK_EN
  rst_seq #(.DOMAINS(DOMAINS), .HOLD_CYC(HOLD), .GAP_CYC(GAP), .ACK_TIMEOUT(8))
    dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bus));
`else
  rst_seq #(.DOMAINS(DOMAINS), .HOLD_CYC(HOLD), .GAP_CYC(GAP))
    dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bus));
`endif

  int checks   = 0;
  int failures = 0;
  bit exp_err  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic check_out(input string name, input logic [DOMAINS-1:0] rn,
                           input logic b, input logic [1:0] c);
    check({name, ".rst_n"}, 32'(bus.rst_n_o), 32'(rn));
    check({name, ".busy"},  32'(bus.busy_o),  32'(b));
    check({name, ".cause"}, 32'(bus.cause_o), 32'(c));
`ifdef RST_SEQ_ACK_EN
    check({name, ".err"},   32'(bus.err_o),   32'(exp_err));
`endif
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Reference model: age = edges since the edge that started the current
  // sequence. Domain k is released once age reaches HOLD + k*GAP; RUN once
  // age reaches HOLD + DOMAINS*GAP.
  int         m_age      = 0;
  bit         m_in_reset = 1'b1;
  logic [1:0] m_cause    = 2'd0;

  function automatic logic [DOMAINS-1:0] m_rst_n();
    logic [DOMAINS-1:0] r;
    for (int k = 0; k < DOMAINS; k++) r[k] = !m_in_reset && (m_age >= HOLD + k * GAP);
    return r;
  endfunction

  function automatic logic m_busy();
    return m_in_reset || (m_age < RUN_AGE);
  endfunction

  task automatic model_edge(input logic sw, input logic wdt);
    if (m_in_reset) begin
      m_in_reset = 1'b0;
      m_age      = 0;
    end else if (wdt) begin
      m_age   = 0;
      m_cause = 2'd2;
    end else if (sw && (m_age >= RUN_AGE)) begin
      m_age   = 0;
      m_cause = 2'd1;
    end else if (m_age < RUN_AGE) begin
      m_age++;
    end
  endtask

  task automatic model_rst();
    m_in_reset = 1'b1;
    m_cause    = 2'd0;
  endtask

  typedef struct {
    string      name;
    logic       sw;     // held for every edge of this record
    logic       wdt;    // held for every edge of this record
    int         edges;
    logic [2:0] rst_n;
    logic       busy;
    logic [1:0] cause;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(input string n, input logic sw, input logic wdt, input int e,
                             input logic [2:0] rn, input logic b, input logic [1:0] c);
    vec_t r;
    r.name = n; r.sw = sw; r.wdt = wdt; r.edges = e;
    r.rst_n = rn; r.busy = b; r.cause = c;
    return r;
  endfunction

  initial begin
    bus.sw_req_i  = 1'b0;
    bus.wdt_req_i = 1'b0;
`ifdef RST_SEQ_ACK_EN
    bus.rst_ack_i = '1;
`endif

    // POR from rst_i deassert; edge 1 is the first edge after deassert.
    vecs.push_back(v("por_hold",     0, 0, 16, 3'b000, 1, 2'd0));
    vecs.push_back(v("por_d0",       0, 0,  1, 3'b001, 1, 2'd0)); // edge 17
    vecs.push_back(v("por_gap",      0, 0,  3, 3'b001, 1, 2'd0)); // edge 20
    vecs.push_back(v("por_d1",       0, 0,  1, 3'b011, 1, 2'd0)); // edge 21
    vecs.push_back(v("por_d2",       0, 0,  4, 3'b111, 1, 2'd0)); // edge 25
    vecs.push_back(v("por_pre_run",  0, 0,  3, 3'b111, 1, 2'd0)); // edge 28
    vecs.push_back(v("por_run",      0, 0,  1, 3'b111, 0, 2'd0)); // edge 29
    // Software request in RUN; domain 0 releases 16 edges after the
    // sampling edge (17 after the edge that raised the pulse).
    vecs.push_back(v("sw_req",       1, 0,  1, 3'b000, 1, 2'd1));
    vecs.push_back(v("sw_hold",      0, 0, 15, 3'b000, 1, 2'd1));
    vecs.push_back(v("sw_d0",        0, 0,  1, 3'b001, 1, 2'd1));
    vecs.push_back(v("sw_run",       0, 0, 12, 3'b111, 0, 2'd1));
    // Watchdog pulse while rst_n = 011.
    vecs.push_back(v("sw_again",     1, 0,  1, 3'b000, 1, 2'd1));
    vecs.push_back(v("to_011",       0, 0, 20, 3'b011, 1, 2'd1));
    vecs.push_back(v("wdt_rel",      0, 1,  1, 3'b000, 1, 2'd2));
    vecs.push_back(v("wdt_hold",     0, 0, 15, 3'b000, 1, 2'd2));
    vecs.push_back(v("wdt_d0",       0, 0,  1, 3'b001, 1, 2'd2));
    vecs.push_back(v("wdt_run",      0, 0, 12, 3'b111, 0, 2'd2));
    // Simultaneous requests; software request during ASSERT is dropped.
    vecs.push_back(v("both_req",     1, 1,  1, 3'b000, 1, 2'd2));
    vecs.push_back(v("assert_mid",   0, 0,  5, 3'b000, 1, 2'd2));
    vecs.push_back(v("sw_in_assert", 1, 0,  1, 3'b000, 1, 2'd2));
    vecs.push_back(v("no_restart",   0, 0, 10, 3'b001, 1, 2'd2));
    vecs.push_back(v("run_again",    0, 0, 12, 3'b111, 0, 2'd2));
    vecs.push_back(v("no_queue",     0, 0,  2, 3'b111, 0, 2'd2));
    // Held watchdog pins the hold counter at its start value.
    vecs.push_back(v("wdt_held",     0, 1,  5, 3'b000, 1, 2'd2));
    vecs.push_back(v("held_release", 0, 0, 16, 3'b001, 1, 2'd2));
    vecs.push_back(v("held_run",     0, 0, 12, 3'b111, 0, 2'd2));

    // Power-on reset state.
    #1 rst_i = 1'b1;
    #1 check_out("reset_state", 3'b000, 1'b1, 2'd0);
    tick();
    tick();
    rst_i = 1'b0;
    #1 check_out("after_deassert", 3'b000, 1'b1, 2'd0);
    #2;

    for (int i = 0; i < vecs.size(); i++) begin
      bus.sw_req_i  = vecs[i].sw;
      bus.wdt_req_i = vecs[i].wdt;
      repeat (vecs[i].edges) tick();
      bus.sw_req_i  = 1'b0;
      bus.wdt_req_i = 1'b0;
      check_out(vecs[i].name, vecs[i].rst_n, vecs[i].busy, vecs[i].cause);
    end

    // Asynchronous reset mid-RELEASE: outputs clear without a clock edge.
    bus.sw_req_i = 1'b1;
    tick();
    bus.sw_req_i = 1'b0;
    repeat (18) tick();
    check_out("pre_async", 3'b001, 1'b1, 2'd1);
    #3 rst_i = 1'b1;
    #1 check_out("async_rst", 3'b000, 1'b1, 2'd0);
    tick();
    #2 rst_i = 1'b0;
    repeat (16) tick();
    check_out("async_hold", 3'b000, 1'b1, 2'd0);
    tick();
    check_out("async_d0", 3'b001, 1'b1, 2'd0);
    repeat (12) tick();
    check_out("async_run", 3'b111, 1'b0, 2'd0);

    // Randomized run against the reference model, from a fresh reset.
    begin
      int   wdt_left;
      logic sw;
      logic wdt;
      wdt_left = 0;
      rst_i = 1'b1;
      model_rst();
      tick();
      rst_i = 1'b0;
      for (int i = 0; i < 1500; i++) begin
        if ($urandom_range(0, 399) == 0) begin
          #2 rst_i = 1'b1;
          model_rst();
          wdt_left = 0;
          #1 check_out($sformatf("rand_async[%0d]", i), m_rst_n(), m_busy(), m_cause);
          tick();
          #2 rst_i = 1'b0;
        end else begin
          sw = ($urandom_range(0, 19) == 0);
          if ((wdt_left == 0) && ($urandom_range(0, 149) == 0)) wdt_left = $urandom_range(1, 6);
          wdt = (wdt_left > 0);
          if (wdt_left > 0) wdt_left--;
          bus.sw_req_i  = sw;
          bus.wdt_req_i = wdt;
          tick();
          model_edge(sw, wdt);
          bus.sw_req_i  = 1'b0;
          bus.wdt_req_i = 1'b0;
          check_out($sformatf("rand[%0d]", i), m_rst_n(), m_busy(), m_cause);
        end
      end
    end

`ifdef RST_SEQ_ACK_EN
    // All acknowledges high: plain gap timing.
    bus.rst_ack_i = 3'b111;
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    repeat (25) tick();
    check_out("ack_d2", 3'b111, 1'b1, 2'd0);
    repeat (4) tick();
    check_out("ack_run", 3'b111, 1'b0, 2'd0);
    // Domain 1 never acknowledges: domain 2 release slips by 8 cycles.
    bus.rst_ack_i = 3'b101;
    bus.sw_req_i  = 1'b1;
    tick();
    bus.sw_req_i  = 1'b0;
    repeat (31) tick();
    check_out("ack_wait", 3'b011, 1'b1, 2'd1);
    tick();
    exp_err = 1'b1;
    check_out("ack_timeout", 3'b111, 1'b1, 2'd1);
    repeat (4) tick();
    check_out("ack_to_run", 3'b111, 1'b0, 2'd1);
    // err_o survives a software reset, clears only on rst_i.
    bus.rst_ack_i = 3'b111;
    bus.sw_req_i  = 1'b1;
    tick();
    bus.sw_req_i  = 1'b0;
    repeat (28) tick();
    check_out("err_sticky", 3'b111, 1'b0, 2'd1);
    #2 rst_i = 1'b1;
    exp_err = 1'b0;
    #1 check_out("err_clear", 3'b000, 1'b1, 2'd0);
    tick();
    rst_i = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
